// File: rtl/fb_sched_if.sv
// fb_sched_if: single-outstanding burst command port between the frame-buffer scheduler and memory
interface fb_sched_if #(parameter int AW = 23);
  logic          cmd_val_o;
  logic          cmd_rdy_i;
  logic          cmd_we_o;
  logic [AW-1:0] cmd_addr_o;
  logic          done_i;
  modport master (output cmd_val_o, cmd_we_o, cmd_addr_o, input cmd_rdy_i, done_i);
  modport slave (input cmd_val_o, cmd_we_o, cmd_addr_o, output cmd_rdy_i, done_i);
endinterface

// File: rtl/fb_sched.sv
// fb_sched: shares one memory burst port between video write and read streams with triple-buffered frames
module fb_sched #(
  parameter int AW          = 23,
  parameter int LW          = 12,
  parameter int BURST       = 16,
  parameter int FRAME_BEATS = 2073600,
  parameter int STRIDE      = 2097152,
  parameter int WURG        = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LW-1:0]     wlvl_i,
  input  logic              wvs_i,
  input  logic [LW-1:0]     rfree_i,
  input  logic              rvs_i,
  fb_sched_if.master        cmd,
  output logic [1:0]        wbuf_o,
  output logic [1:0]        rbuf_o,
  output logic              drop_o,
  output logic              underrun_o
);
  localparam int CW = $clog2(FRAME_BEATS + 1);
  localparam logic [CW-1:0] FB  = CW'(FRAME_BEATS);
  localparam logic [CW-1:0] BST = CW'(BURST);
  localparam logic [AW-1:0] STR = AW'(STRIDE);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        state_q, state_d;
  logic [1:0]    wbuf_q, wbuf_d, rbuf_q, rbuf_d, fresh_q, fresh_d, fresh_w;
  logic          fresh_val_q, fresh_val_d, fresh_val_w;
  logic          have_frame_q, have_frame_d, last_w_q, last_w_d;
  logic          cmd_val_q, cmd_val_d, cmd_we_q, cmd_we_d;
  logic          drop_q, drop_d, underrun_q, underrun_d;
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d, waddr, raddr;
  logic          w_el, r_el, w_win, grant, acc, w_pend, r_pend, w_full;
  assign waddr = AW'(wbuf_q) * STR + AW'(wcnt_q);
  assign raddr = AW'(rbuf_q) * STR + AW'(rcnt_q);
  always_comb begin
    w_el = wlvl_i >= LW'(BURST) && wcnt_q < FB;
    r_el = have_frame_q && rfree_i >= LW'(BURST) && rcnt_q < FB;
    w_win = w_el && (wlvl_i >= LW'(WURG) || !r_el || !last_w_q);
    grant = state_q == IDLE && (w_el || r_el);
    acc = state_q == ISSUE && cmd.cmd_rdy_i;
    // a burst accepted but not yet finished belongs to the frame after a pulse
    w_pend = cmd_we_q && (acc || state_q == WAIT);
    r_pend = !cmd_we_q && (acc || state_q == WAIT);
    w_full = wcnt_q == FB;
    state_d = grant ? ISSUE : acc ? WAIT : (state_q == WAIT && cmd.done_i) ? IDLE : state_q;
    cmd_val_d = state_d == ISSUE;
    cmd_we_d = grant ? w_win : cmd_we_q;
    cmd_addr_d = grant ? (w_win ? waddr : raddr) : cmd_addr_q;
    last_w_d = acc ? cmd_we_q : last_w_q;
    wcnt_d = wvs_i ? (w_pend ? BST : '0) : wcnt_q + ((acc && cmd_we_q) ? BST : '0);
    rcnt_d = rvs_i ? (r_pend ? BST : '0) : rcnt_q + ((acc && !cmd_we_q) ? BST : '0);
    fresh_w = (wvs_i && w_full) ? wbuf_q : fresh_q;
    fresh_val_w = (wvs_i && w_full) || fresh_val_q;
    wbuf_d = (wvs_i && w_full) ? 2'd3 - wbuf_q - rbuf_q : wbuf_q;
    have_frame_d = have_frame_q || (wvs_i && w_full);
    drop_d = wvs_i && !w_full;
    underrun_d = rvs_i && have_frame_q && rcnt_q < FB;
    rbuf_d = (rvs_i && fresh_val_w) ? fresh_w : rbuf_q;
    fresh_d = fresh_w;
    fresh_val_d = fresh_val_w && !rvs_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q      <= IDLE;
      wbuf_q       <= 2'd0;
      rbuf_q       <= 2'd2;
      fresh_q      <= 2'd0;
      fresh_val_q  <= 1'b0;
      have_frame_q <= 1'b0;
      last_w_q     <= 1'b0;
      cmd_val_q    <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      drop_q       <= 1'b0;
      underrun_q   <= 1'b0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      wbuf_q       <= wbuf_d;
      rbuf_q       <= rbuf_d;
      fresh_q      <= fresh_d;
      fresh_val_q  <= fresh_val_d;
      have_frame_q <= have_frame_d;
      last_w_q     <= last_w_d;
      cmd_val_q    <= cmd_val_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      drop_q       <= drop_d;
      underrun_q   <= underrun_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
    end
  assign cmd.cmd_val_o  = cmd_val_q;
  assign cmd.cmd_we_o   = cmd_we_q;
  assign cmd.cmd_addr_o = cmd_addr_q;
  assign wbuf_o         = wbuf_q;
  assign rbuf_o         = rbuf_q;
  assign drop_o         = drop_q;
  assign underrun_o     = underrun_q;
endmodule
